// File: rtl/fsm_3a_if.sv
// Handshake bundle between the varint FIFO, the varint encoder and the output-merge FSM.
// The master modport is the encoder side; the slave modport is the FIFO/consumer side.
interface fsm_3a_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 10
);
    logic              in_fifo_empty;
    logic              in_fifo_pop;
    logic [DATA_W-1:0] in_fifo_q;
    logic [IDX_W-1:0]  in_index_q;
    logic [7:0]        varint_byte;
    logic              varint_data_valid;
    logic              varint_data_accepted;
    logic [IDX_W-1:0]  varint_in_index_q;
    logic [IDX_W-1:0]  varint_out_index_q;
    logic              varint_encoding;

    modport master (
        input  in_fifo_empty, in_fifo_q, in_index_q, varint_data_accepted,
        output in_fifo_pop, varint_byte, varint_data_valid,
               varint_in_index_q, varint_out_index_q, varint_encoding
    );

    modport slave (
        output in_fifo_empty, in_fifo_q, in_index_q, varint_data_accepted,
        input  in_fifo_pop, varint_byte, varint_data_valid,
               varint_in_index_q, varint_out_index_q, varint_encoding
    );
endinterface

// File: rtl/fsm_3a.sv
// Base-128 varint encoder: pops one value + field index, then presents the encoded
// bytes one at a time to the merge FSM over a valid/accepted handshake.
module fsm_3a #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 10
) (
    input logic       clk,
    input logic       reset_n,
    fsm_3a_if.master  vif
);
    // state   | meaning
    // INIT    | post-reset, all outputs quiet
    // WAIT_IN | idle, waiting for a non-empty FIFO
    // POP     | one-cycle pop strobe
    // LOAD    | capture FIFO value and index
    // EMIT    | present one byte until accepted
    // SHIFT   | bubble between bytes of one value
    localparam int MAXB = (DATA_W + 6) / 7;

    localparam logic [5:0] S_INIT    = 6'b000001;
    localparam logic [5:0] S_WAIT_IN = 6'b000010;
    localparam logic [5:0] S_POP     = 6'b000100;
    localparam logic [5:0] S_LOAD    = 6'b001000;
    localparam logic [5:0] S_EMIT    = 6'b010000;
    localparam logic [5:0] S_SHIFT   = 6'b100000;

    logic [5:0]        state_q, state_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [IDX_W-1:0]  idx_in_q, idx_in_d;
    logic [IDX_W-1:0]  idx_out_q, idx_out_d;
    logic              more;

    // The byte-count cap forces the final byte even if upper bits remain.
    always_comb begin
        more = ((val_q >> 7) != '0) && (bcnt_q != 4'(MAXB - 1));
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        bcnt_d    = bcnt_q;
        idx_in_d  = idx_in_q;
        idx_out_d = idx_out_q;
        case (state_q)
            S_INIT:    state_d = S_WAIT_IN;
            S_WAIT_IN: if (!vif.in_fifo_empty) state_d = S_POP;
            S_POP:     state_d = S_LOAD;
            S_LOAD: begin
                val_d     = vif.in_fifo_q;
                idx_in_d  = vif.in_index_q;
                idx_out_d = vif.in_index_q;
                bcnt_d    = '0;
                state_d   = S_EMIT;
            end
            S_EMIT: begin
                if (vif.varint_data_accepted) begin
                    if (more) begin
                        val_d   = val_q >> 7;
                        bcnt_d  = bcnt_q + 4'd1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_SHIFT:   state_d = S_EMIT;
            default:   state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_INIT;
            val_q     <= '0;
            bcnt_q    <= '0;
            idx_in_q  <= '0;
            idx_out_q <= '0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            bcnt_q    <= bcnt_d;
            idx_in_q  <= idx_in_d;
            idx_out_q <= idx_out_d;
        end
    end

    assign vif.in_fifo_pop        = (state_q == S_POP);
    assign vif.varint_data_valid  = (state_q == S_EMIT);
    assign vif.varint_byte        = (state_q == S_EMIT) ? {more, val_q[6:0]} : 8'h00;
    assign vif.varint_encoding    = (state_q == S_LOAD) || (state_q == S_EMIT) ||
                                    (state_q == S_SHIFT);
    assign vif.varint_in_index_q  = idx_in_q;
    assign vif.varint_out_index_q = idx_out_q;
endmodule

// File: doc/fsm_3a.md
Name: fsm_3a

Overview:
Varint encoder feeding the output-merge FSM (fsm_3).
- Pops one unsigned value plus its field index from the varint input FIFO.
- Encodes the value as a protobuf base-128 varint.
- Presents the bytes one at a time to fsm_3 over a valid/accepted handshake.
- Exports the index being encoded (varint_in_index_q) and the index of the byte presented (varint_out_index_q), which fsm_3 uses for in-order merging with the raw-data path.

Parameters:
DATA_W, 64, width of input value; max bytes per value = ceil(DATA_W/7) (10 at default)
IDX_W, 10, width of field index

Ports:
clk  in  1  clock, all logic on posedge
reset_n  in  1  synchronous active-low reset
in_fifo_empty  in  1  input FIFO empty
in_fifo_pop  out  1  pop strobe, one-cycle pulse; FIFO q valid the cycle after the pop
in_fifo_q  in  DATA_W  value to encode
in_index_q  in  IDX_W  field index of in_fifo_q
varint_byte  out  8  current encoded byte
varint_data_valid  out  1  varint_byte / varint_out_index_q valid
varint_data_accepted  in  1  one-cycle pulse from fsm_3: byte consumed
varint_in_index_q  out  IDX_W  index of value currently loaded
varint_out_index_q  out  IDX_W  index of byte presented
varint_encoding  out  1  high while a loaded value still has unaccepted bytes

Behaviour:
Clock and reset
- Single clock clk. Reset is synchronous, active-low on reset_n.
- While reset_n=0 at a posedge: state<=INIT; value register, byte counter and both index registers <=0.
- All outputs are 0 during and immediately after reset.

Registers
- val: DATA_W bits.
- bcnt: 4 bits.
- idx_in, idx_out: IDX_W bits.

States (one-hot): INIT, WAIT_IN, POP, LOAD, EMIT, SHIFT.
- INIT: all outputs 0; next WAIT_IN.
- WAIT_IN: varint_encoding=0. If ~in_fifo_empty -> POP, else stay.
- POP: in_fifo_pop=1 (exactly one cycle). Next LOAD.
- LOAD:
  - val<=in_fifo_q; idx_in<=in_index_q; idx_out<=in_index_q; bcnt<=0.
  - varint_encoding=1 from this cycle on.
  - Next EMIT.
- EMIT:
  - varint_data_valid=1.
  - varint_byte={more, val[6:0]}, where more = (val>>7)!=0, or bcnt==MAXB-1 forces more=0.
  - Byte and indices are held stable until varint_data_accepted.
  - On accepted:
    - if more=0 -> WAIT_IN, and varint_encoding drops the next cycle;
    - else val<=val>>7, bcnt<=bcnt+1 -> SHIFT.
- SHIFT: varint_data_valid=0 (one bubble so fsm_3, returning to WAIT_DATA, never sees a stale valid); next EMIT.

Handshake and timing
- varint_data_valid is a Moore output of EMIT only. It falls in the cycle after the accepted pulse.
- Latency: first valid appears 2 cycles after the pop cycle.
- Minimum spacing between bytes of one value: accept cycle + 1 bubble.
- varint_data_accepted outside EMIT is ignored (no state change).

Encoding rules
- Value 0 encodes to the single byte 0x00.
- All-ones at DATA_W=64 encodes to 10 bytes, the last being 0x01.
- The MAXB cap guarantees termination for any DATA_W.

Index rules
- varint_in_index_q and varint_out_index_q are both driven from LOAD and are equal for this single-value-in-flight design.
- Indices are copied only; no arithmetic is performed, so index wrap (1023->0) is handled entirely by fsm_3.

Boundary conditions
- Empty FIFO: no pop and no valid; the FSM parks in WAIT_IN.
- in_fifo_empty rising during POP: pop still completes. Upstream guarantees that ~empty seen in WAIT_IN means data is present.
- Reset mid-value (any state): the value is discarded, valid drops at that edge, and no further pop occurs until WAIT_IN is re-entered.

Test Plan:
- FIFO holds value 0, index 5; accept 1 cycle after valid -> one byte 0x00, out_index=5, encoding high from LOAD until the cycle after accept, exactly one in_fifo_pop.
- Value 300, index 7 -> bytes 0xAC then 0x02, valid low for exactly 1 cycle between them, both bytes with out_index=7.
- Value 64'hFFFF_FFFF_FFFF_FFFF -> nine bytes 0xFF then 0x01, bcnt reaches 9, return to WAIT_IN.
- Byte presented, accepted withheld 6 cycles -> valid, varint_byte and indices stable all 6 cycles; single advance on the pulse; spurious accepted pulses in WAIT_IN or SHIFT cause no change.
- Two back-to-back entries (value 1 index 3, value 128 index 4) -> 0x01 @3; then 0x80, 0x01 @4; second pop only after the first value's last accept.
- reset_n low for 1 cycle during second byte of 300 -> valid=0, encoding=0, indices=0 next cycle; after release, next FIFO entry encodes from scratch.
